// File: rtl/afisor_multiplexat.sv
// afisor_multiplexat
//   Scan controller for a time-multiplexed NUM_DIGITS-digit 7-segment display.
//   A pending buffer captures new digits on load; the displayed word (active)
//   only takes them over at a frame boundary, so a frame is never torn.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      1 = scan runs, 0 = scan frozen and display dark
//   load        1-cycle strobe, captures data_in into the pending buffer
//   data_in     packed digits, digit i = data_in[4*i+3:4*i]
//   digit_out   nibble of the scanned digit, feeds the shared segment decoder
//   digit_en    one-hot common enable of the scanned digit, all 0 = dark
//   frame_done  1-cycle pulse after the last slot of a frame
//   pending     captured data not yet shown
module afisor_multiplexat #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter bit LZS         = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             r_presc;
  logic [IW-1:0]             r_idx;
  logic [4*NUM_DIGITS-1:0]   r_active;
  logic [4*NUM_DIGITS-1:0]   r_pend_buf;
  logic                      r_pending;
  logic                      r_frame_done;

  logic                      w_tick;
  logic                      w_boundary;
  logic [NUM_DIGITS-1:0]     w_zero_from;
  logic [NUM_DIGITS-1:0]     w_en;
  logic [3:0]                w_digit;

  assign w_tick     = enable && (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_pend_buf   <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;

      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else if (enable) begin
        r_presc <= r_presc + PW'(1);
      end

      // Old pending data is applied even if a new load lands on the same
      // edge; the new word then stays pending for the next frame.
      if (w_boundary && r_pending) begin
        r_active <= r_pend_buf;
      end

      if (load) begin
        r_pend_buf <= data_in;
        r_pending  <= 1'b1;
      end else if (w_boundary) begin
        r_pending  <= 1'b0;
      end
    end
  end

  always_comb begin
    logic v_all_zero;
    v_all_zero  = 1'b1;
    w_zero_from = '0;
    w_digit     = '0;
    w_en        = '0;

    // w_zero_from[k]: digits k..NUM_DIGITS-1 of the shown word are all zero
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_all_zero     = v_all_zero && (r_active[4*k +: 4] == 4'd0);
      w_zero_from[k] = v_all_zero;
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_digit = r_active[4*k +: 4];
        // rst_n gating keeps the display dark while reset is held
        if (enable && rst_n && !(LZS && (k > 0) && w_zero_from[k])) begin
          w_en[k] = 1'b1;
        end
      end
    end
  end

  assign digit_out  = w_digit;
  assign digit_en   = w_en;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule
